// File: rtl/serial_rx_package.sv
// ============================================================================
//  Module   : serial_rx_package
//  Purpose  : Receives 8N1-style serial frames and reassembles 2**AddressWidth
//             words into one wide package word (first word in the MSBs).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_rx_package #(
  parameter int AddressWidth     = 3,
  parameter int WordWidth        = 8,
  parameter int SerialTimerWidth = 8,
  parameter int IdleTimeoutBits  = 16
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                rx,
  output logic [WordWidth*(2**AddressWidth)-1:0] data,
  output logic                                valid,
  output logic                                frameError,
  output logic                                busy
);

  localparam int c_WORDS       = 2**AddressWidth;
  localparam int c_PKG_W       = WordWidth * c_WORDS;
  localparam int c_CNT_W       = AddressWidth + 1;
  localparam int c_IDX_W       = $clog2(WordWidth) + 1;
  localparam int c_TO_CYCLES   = IdleTimeoutBits * (2**SerialTimerWidth);
  localparam int c_TO_W        = $clog2(c_TO_CYCLES) + 1;
  localparam logic [SerialTimerWidth-1:0] c_HALF = SerialTimerWidth'(2**(SerialTimerWidth-1) - 1);
  localparam logic [SerialTimerWidth-1:0] c_FULL = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t                      r_state;
  logic [1:0]                  r_sync;
  logic                        r_rxs_d;
  logic [1:0]                  r_flush;
  logic                        r_armed;
  logic [SerialTimerWidth-1:0] r_t;
  logic [c_IDX_W-1:0]          r_idx;
  logic [WordWidth-1:0]        r_byte;
  logic [c_PKG_W-1:0]          r_pkg;
  logic [c_PKG_W-1:0]          r_data;
  logic [c_CNT_W-1:0]          r_cnt;
  logic [c_TO_W-1:0]           r_to;
  logic                        r_valid;
  logic                        r_fe;

  logic                        w_rxs;
  logic                        w_fall;
  logic                        w_tx;
  logic [c_PKG_W+WordWidth-1:0] w_ext;
  logic [c_PKG_W-1:0]          w_pkg_next;

  assign w_rxs      = r_sync[1];
  // Edges are only trusted once the synchronizer holds real samples and the
  // line has been seen high, so a reset mid-frame cannot start a bogus frame.
  assign w_fall     = r_armed & r_rxs_d & ~w_rxs;
  assign w_tx       = (r_t == '0);
  assign w_ext      = {r_pkg, r_byte};
  assign w_pkg_next = w_ext[c_PKG_W-1:0];

  assign data       = r_data;
  assign valid      = r_valid;
  assign frameError = r_fe;
  assign busy       = (r_state != S_IDLE) || (r_cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_sync  <= 2'b11;
      r_rxs_d <= 1'b1;
      r_flush <= 2'b00;
      r_armed <= 1'b0;
      r_t     <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_pkg   <= '0;
      r_data  <= '0;
      r_cnt   <= '0;
      r_to    <= '0;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], rx};
      r_rxs_d <= w_rxs;
      r_flush <= {r_flush[0], 1'b1};
      if (r_flush[1] && w_rxs) r_armed <= 1'b1;
      r_valid <= 1'b0;
      r_fe    <= 1'b0;
      r_t     <= r_t - SerialTimerWidth'(1);

      case (r_state)
        S_IDLE: begin
          if (w_fall) begin
            r_t     <= c_HALF;
            r_to    <= '0;
            r_state <= S_START;
          end else if (r_cnt != '0) begin
            if (r_to == c_TO_W'(c_TO_CYCLES - 1)) begin
              r_cnt <= '0;
              r_to  <= '0;
            end else begin
              r_to <= r_to + c_TO_W'(1);
            end
          end else begin
            r_to <= '0;
          end
        end
        S_START: begin
          if (w_tx) begin
            if (!w_rxs) begin
              r_t     <= c_FULL;
              r_idx   <= '0;
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
            end
          end
        end
        S_DATA: begin
          if (w_tx) begin
            r_byte <= {w_rxs, r_byte[WordWidth-1:1]};
            r_t    <= c_FULL;
            if (r_idx == c_IDX_W'(WordWidth - 1)) r_state <= S_STOP;
            else                                  r_idx   <= r_idx + c_IDX_W'(1);
          end
        end
        S_STOP: begin
          if (w_tx) begin
            if (w_rxs) begin
              r_pkg   <= w_pkg_next;
              r_state <= S_IDLE;
              if (r_cnt == c_CNT_W'(c_WORDS - 1)) begin
                r_data  <= w_pkg_next;
                r_valid <= 1'b1;
                r_cnt   <= '0;
              end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
              end
            end else begin
              r_fe    <= 1'b1;
              r_cnt   <= '0;
              r_pkg   <= '0;
              r_state <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          if (w_rxs) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_rx_package.sv
// ============================================================================
//  Module   : tb_serial_rx_package
//  Purpose  : Randomized self-checking bench for serial_rx_package against a
//             byte-queue package model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_serial_rx_package;

  localparam int c_BIT = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rx  = 1'b1;
  logic [15:0] data;
  logic        valid;
  logic        frameError;
  logic        busy;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  int          n_valid  = 0;
  int          n_fe     = 0;
  int          valid_cyc = 0;
  int          stop_cyc  = 0;
  logic [15:0] last_data = '0;
  logic        prev_valid = 1'b0;
  logic [7:0]  q[$];

  serial_rx_package #(
    .AddressWidth    (1),
    .WordWidth       (8),
    .SerialTimerWidth(4),
    .IdleTimeoutBits (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data      (data),
    .valid     (valid),
    .frameError(frameError),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: counts pulses and checks width and exclusivity.
  always @(negedge clk) begin
    if (valid || frameError) chk("excl", {31'd0, valid & frameError}, 32'd0);
    if (valid) begin
      chk("valid_width", {31'd0, prev_valid}, 32'd0);
      n_valid++;
      last_data = data;
      valid_cyc = cyc;
    end
    if (frameError) n_fe++;
    prev_valid = valid;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int rst_bit);
    rx = 1'b0;
    wait_clk(c_BIT);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == rst_bit) begin
        wait_clk(c_BIT / 2);
        rst = 1'b0;
        #1;
        chk("rst_data", {16'd0, data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_valid", {31'd0, valid}, 32'd0);
        wait_clk(c_BIT / 2);
      end else begin
        wait_clk(c_BIT);
      end
    end
    rx = stop_ok;
    stop_cyc = cyc;
    wait_clk(c_BIT);
    if (!stop_ok) wait_clk(40);
    rx = 1'b1;
  endtask

  // Sends one frame, predicts its outcome from the byte queue, then idles.
  task automatic do_frame(input logic [7:0] b, input logic stop_ok, input int gap_bits);
    int          v0, f0, exp_v, exp_f;
    logic [15:0] exp_d;
    v0 = n_valid; f0 = n_fe; exp_v = 0; exp_f = 0; exp_d = '0;
    if (stop_ok) begin
      q.push_back(b);
      if (q.size() == 2) begin
        exp_v = 1;
        exp_d = {q[0], q[1]};
        q.delete();
      end
    end else begin
      exp_f = 1;
      q.delete();
    end
    send_frame(b, stop_ok, -1);
    chk("valid_cnt", n_valid - v0, exp_v);
    chk("fe_cnt", n_fe - f0, exp_f);
    if (exp_v == 1) begin
      chk("data", {16'd0, last_data}, {16'd0, exp_d});
      chk("valid_lat", {31'd0, (valid_cyc - stop_cyc >= 8) && (valid_cyc - stop_cyc <= 13)}, 32'd1);
    end
    wait_clk(gap_bits * c_BIT);
    if (gap_bits >= 17) q.delete();
    chk("busy", {31'd0, busy}, {31'd0, q.size() != 0});
  endtask

  task automatic do_glitch();
    int v0, f0;
    v0 = n_valid; f0 = n_fe;
    rx = 1'b0;
    wait_clk(4);
    rx = 1'b1;
    wait_clk(2 * c_BIT);
    chk("glitch_pulses", (n_valid - v0) + (n_fe - f0), 0);
    chk("glitch_busy", {31'd0, busy}, {31'd0, q.size() != 0});
  endtask

  initial begin
    // Reset held with the line toggling.
    for (int i = 0; i < 24; i++) begin
      rx = 1'($urandom);
      wait_clk(1);
      if (i % 6 == 5) begin
        chk("reset_data", {16'd0, data}, 32'd0);
        chk("reset_flags", {29'd0, valid, frameError, busy}, 32'd0);
      end
    end
    rx = 1'b1;
    wait_clk(2);
    rst = 1'b1;
    wait_clk(40);
    chk("post_reset_pulses", n_valid + n_fe, 0);

    do_frame(8'hA5, 1'b1, 0);
    do_frame(8'h3C, 1'b1, 2);

    do_frame(8'h55, 1'b0, 1);
    do_frame(8'h12, 1'b1, 0);
    do_frame(8'h34, 1'b1, 2);

    do_glitch();

    do_frame(8'h77, 1'b1, 17);
    do_frame(8'h88, 1'b1, 0);
    do_frame(8'h99, 1'b1, 2);

    for (int i = 0; i < 30; i++) begin
      logic [7:0] b;
      logic       ok;
      int         gap;
      b   = 8'($urandom);
      ok  = ($urandom_range(0, 7) != 0);
      gap = ($urandom_range(0, 5) == 0) ? 18 : int'($urandom_range(0, 3));
      if (!ok && gap == 0) gap = 1;
      do_frame(b, ok, gap);
      if ($urandom_range(0, 5) == 0) do_glitch();
    end

    // Make sure a package is on data, then reset partway through a frame.
    do_frame(8'h5A, 1'b1, 0);
    do_frame(8'hC3, 1'b1, 1);
    do_frame(8'h11, 1'b1, 0);
    send_frame(8'h22, 1'b1, 3);
    wait_clk(2 * c_BIT);
    rst = 1'b1;
    q.delete();
    wait_clk(2 * c_BIT);
    chk("after_rst_data", {16'd0, data}, 32'd0);
    do_frame(8'hDE, 1'b1, 0);
    do_frame(8'hAD, 1'b1, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_rx_package.md
# serial_rx_package

Receive side of the team's serial package link: reassembles a package of `2**AddressWidth` words sent as 8N1-style UART frames back into one wide word. Matches the serial package transmitter's framing and bit timing. Lets a host or second board capture debug packages, such as `{counter, bestIndividual}` from the morphologic GA debug top, and loop them back for self-test.

## Interface
Parameters:
- `AddressWidth`, 3: package holds `2**AddressWidth` words.
- `WordWidth`, 8: data bits per serial frame.
- `SerialTimerWidth`, 8: bit period is `2**SerialTimerWidth` clocks; must be ≥ 2.
- `IdleTimeoutBits`, 16: bit periods of idle line after which a partial package is discarded.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `rx`, input, 1: serial line. Idles high. Asynchronous to `clk`.
- `data`, output, `WordWidth*2**AddressWidth`: last complete package. The first word received occupies the MSBs.
- `valid`, output, 1: one-cycle pulse when `data` is updated.
- `frameError`, output, 1: one-cycle pulse on a bad stop bit.
- `busy`, output, 1: high while any state other than IDLE is active, or while a partial package is held.

## Operation
- `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rxs`.
- Bit timer `T` is `SerialTimerWidth` bits wide. Word counter `cnt` is `AddressWidth+1` bits wide. Bit index is `$clog2(WordWidth)+1` bits wide.
- State machine:
  - IDLE: a falling edge on `rxs` loads `T` with the half-bit count and moves to START.
  - START: when `T` expires, sample `rxs`. If 0, go to DATA with `T` reloaded to a full bit and bit index 0. If 1, the start was a glitch: return to IDLE. Partial package is kept.
  - DATA: on each `T` expiry, shift `rxs` into the byte register LSB-first. After `WordWidth` samples, go to STOP.
  - STOP: on `T` expiry, sample `rxs`.
    - If 1: shift the byte into the package register with `pkg <= {pkg, byte}`, low-order insert, and increment `cnt`. If `cnt` reaches `2**AddressWidth`, copy `pkg` to `data`, pulse `valid`, clear `cnt`. Go to IDLE.
    - If 0: pulse `frameError`, clear `cnt`, discard the partial package, go to BREAK.
  - BREAK: wait for `rxs` = 1, then go to IDLE. A line held low never produces frames.
- Idle timeout: in IDLE with `cnt` ≠ 0, a counter runs. After `IdleTimeoutBits * 2**SerialTimerWidth` clocks it clears `cnt` silently, with no pulse. A falling edge restarts it.
- `data` holds its value until the next complete package.
- Reset mid-frame aborts immediately. The next frame is only recognized after the line returns high and a fresh falling edge occurs.

## Timing
- Reset values: `data` = 0, `valid` = 0, `frameError` = 0, `busy` = 0, state = IDLE, `cnt` = 0, synchronizer = 11.
- `rx` to `rxs` delay: 2 clocks.
- Sampling points, measured from the falling edge seen on `rxs`:
  - Start bit at `2**(SerialTimerWidth-1)` clocks.
  - Data bit *k* at `2**(SerialTimerWidth-1) + (k+1)*2**SerialTimerWidth` clocks.
  - Stop bit one bit period after the last data bit.
- `valid` and `frameError` assert in the clock after the stop-bit sample. Each is high for exactly 1 cycle, and they are mutually exclusive.
- `valid` and the update of `data` happen on the same edge.
- Back-to-back frames are accepted: IDLE is re-entered at the stop-bit midpoint, so the next start edge half a bit later is detected.
- The transmitter's bit period must be within ±2% for reliable capture.

## Test plan
Bench settings: `SerialTimerWidth=4` (16 clocks/bit), `AddressWidth=1`, `WordWidth=8`.
- Reset: hold `rst`=0 with `rx` toggling. Expect all outputs 0 and no pulses; after release, no `valid` occurs until a full frame is sent.
- Normal package: send bytes 0xA5 then 0x3C back-to-back. Expect exactly one `valid` pulse, 1 cycle after the second stop-bit sample, with `data`=0xA53C.
- Framing error: send 0x55 with stop bit 0, hold `rx` low for 40 clocks, then send 0x12, 0x34. Expect one `frameError` pulse, no `valid` for 0x55, and then `valid` with `data`=0x1234.
- Glitch: pulse `rx` low for 4 clocks. Expect a return to IDLE, no pulses, and `busy` back to 0.
- Timeout: send 0x77, idle for 17×16 clocks, send 0x88, 0x99. Expect a single `valid` with `data`=0x8899; 0x77 is never reported.
- Async reset mid-byte: assert `rst` at data bit 3 of the second byte. Expect `data` to return to 0 immediately. After release, a full package 0xDE, 0xAD gives `data`=0xDEAD.
